sound_i2s_tx: RTL and testbench



---
 rtl/sound_i2s_tx_pkg.sv | 16 +
 rtl/sound_i2s_tx_clkgen.sv | 35 +++
 rtl/sound_i2s_tx.sv | 97 +++++++++
 tb/tb_sound_i2s_tx.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/sound_i2s_tx_pkg.sv
// Shared sound configuration and I2S helpers: board DAC framing defaults and
// the word-select pattern for a frame position.
package sound_i2s_tx_pkg;

    localparam int unsigned SND_WIDTH         = 16;
    localparam int unsigned SND_I2S_DATA_BITS = 16;
    localparam int unsigned SND_I2S_SLOT_BITS = 32;
    localparam int unsigned SND_I2S_CLK_DIV   = 4;

    // Philips one-bit lead: right-channel select spans the last bit of the
    // left slot through the second-to-last bit of the right slot.
    function automatic logic lrck_for_pos(input int unsigned pos, input int unsigned slot_bits);
        return (pos >= slot_bits - 1) && (pos <= 2 * slot_bits - 2);
    endfunction

endpackage

// File: rtl/sound_i2s_tx_clkgen.sv
// Bit-clock generator: divides clk down to BCLK and flags the cycle before
// each BCLK edge so downstream registers can move in step with it.
module sound_i2s_tx_clkgen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic bclk,
    output logic fall_c,
    output logic rise_c
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             tc_c;

    assign tc_c   = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign fall_c = tc_c & bclk;
    assign rise_c = tc_c & ~bclk;

    // Divider and BCLK register; BCLK toggles as the divider wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (tc_c) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/sound_i2s_tx.sv
// I2S master transmitter: sends the mono mixer sample on both channels of a
// Philips-format frame, latching a fresh sample once per frame.
module sound_i2s_tx
    import sound_i2s_tx_pkg::*;
#(
    parameter int unsigned WIDTH     = SND_WIDTH,
    parameter int unsigned DATA_BITS = SND_I2S_DATA_BITS,
    parameter int unsigned SLOT_BITS = SND_I2S_SLOT_BITS,
    parameter int unsigned CLK_DIV   = SND_I2S_CLK_DIV
) (
    input  logic             CLK,
    input  logic             RESET_n,
    input  logic [WIDTH-1:0] IN,
    output logic             I2S_BCLK,
    output logic             I2S_LRCK,
    output logic             I2S_DATA,
    output logic             SAMPLE_STROBE
);

    localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
    localparam int unsigned POS_W      = (FRAME_BITS > 2) ? $clog2(FRAME_BITS) : 1;

    if (SLOT_BITS < DATA_BITS) begin : g_bad_slot
        $error("sound_i2s_tx: SLOT_BITS must be >= DATA_BITS");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("sound_i2s_tx: CLK_DIV must be >= 1");
    end

    logic                 fall_c;
    logic                 bclk_rise_unused;
    logic [WIDTH-1:0]     in_unused;
    logic [DATA_BITS-1:0] sample_fmt_c;
    logic [POS_W-1:0]     pos;
    logic [POS_W-1:0]     pos_next_c;
    logic                 slot_start_c;
    logic                 capture_c;
    logic [DATA_BITS-1:0] shadow;
    logic [DATA_BITS-1:0] shreg;

    assign in_unused = IN;

    sound_i2s_tx_clkgen #(
        .CLK_DIV(CLK_DIV)
    ) u_clkgen (
        .clk    (CLK),
        .rst_n  (RESET_n),
        .bclk   (I2S_BCLK),
        .fall_c (fall_c),
        .rise_c (bclk_rise_unused)
    );

    // Sample formatting: keep the sign bit as MSB, truncate or zero-fill LSBs.
    if (WIDTH >= DATA_BITS) begin : g_trunc
        assign sample_fmt_c = IN[WIDTH-1 -: DATA_BITS];
    end else begin : g_pad
        assign sample_fmt_c = {IN, {(DATA_BITS - WIDTH){1'b0}}};
    end

    always_comb begin
        pos_next_c   = (pos == POS_W'(FRAME_BITS - 1)) ? '0 : pos + POS_W'(1);
        slot_start_c = (pos_next_c == '0) || (pos_next_c == POS_W'(SLOT_BITS));
        capture_c    = (pos_next_c == POS_W'(FRAME_BITS - 1));
    end

    // Frame sequencer: everything moves on the BCLK fall so LRCK/DATA are
    // stable across the receiver's sampling rise. The slot shift register
    // empties to zeros after DATA_BITS, which produces the slot padding.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            pos           <= POS_W'(FRAME_BITS - 1);
            shadow        <= '0;
            shreg         <= '0;
            I2S_LRCK      <= 1'b0;
            I2S_DATA      <= 1'b0;
            SAMPLE_STROBE <= 1'b0;
        end else begin
            SAMPLE_STROBE <= 1'b0;
            if (fall_c) begin
                pos      <= pos_next_c;
                I2S_LRCK <= lrck_for_pos(32'(pos_next_c), SLOT_BITS);
                if (slot_start_c) begin
                    I2S_DATA <= shadow[DATA_BITS-1];
                    shreg    <= shadow << 1;
                end else begin
                    I2S_DATA <= shreg[DATA_BITS-1];
                    shreg    <= shreg << 1;
                end
                if (capture_c) begin
                    shadow        <= sample_fmt_c;
                    SAMPLE_STROBE <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sound_i2s_tx.sv
// Directed bench for sound_i2s_tx: frame timing, sample capture, formatting,
// slot padding and mid-frame reset across four parameterisations.
module tb_sound_i2s_tx;

    logic        clk;
    logic        rst_n;
    logic [15:0] in16;
    logic [11:0] in12;
    logic [19:0] in20;
    logic [23:0] in24;

    logic b16, l16, d16, s16;
    logic b12, l12, d12, s12;
    logic b20, l20, d20, s20;
    logic b24, l24, d24, s24;

    int total;
    int bad;
    int cyc;

    logic [15:0] exp16 [4];

    sound_i2s_tx #(.WIDTH(16), .DATA_BITS(16), .SLOT_BITS(16), .CLK_DIV(2)) u_dut16 (
        .CLK(clk), .RESET_n(rst_n), .IN(in16),
        .I2S_BCLK(b16), .I2S_LRCK(l16), .I2S_DATA(d16), .SAMPLE_STROBE(s16)
    );
    sound_i2s_tx #(.WIDTH(12), .DATA_BITS(16), .SLOT_BITS(16), .CLK_DIV(2)) u_dut12 (
        .CLK(clk), .RESET_n(rst_n), .IN(in12),
        .I2S_BCLK(b12), .I2S_LRCK(l12), .I2S_DATA(d12), .SAMPLE_STROBE(s12)
    );
    sound_i2s_tx #(.WIDTH(20), .DATA_BITS(16), .SLOT_BITS(16), .CLK_DIV(2)) u_dut20 (
        .CLK(clk), .RESET_n(rst_n), .IN(in20),
        .I2S_BCLK(b20), .I2S_LRCK(l20), .I2S_DATA(d20), .SAMPLE_STROBE(s20)
    );
    sound_i2s_tx #(.WIDTH(24), .DATA_BITS(24), .SLOT_BITS(32), .CLK_DIV(2)) u_dut24 (
        .CLK(clk), .RESET_n(rst_n), .IN(in24),
        .I2S_BCLK(b24), .I2S_LRCK(l24), .I2S_DATA(d24), .SAMPLE_STROBE(s24)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge count since the last reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Returns #1 after edge n.
    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_frames(input int nframes, input string tag);
        logic [31:0] w16, lr16, w12, w20;
        logic [63:0] w24, lr24;
        int f;
        w16 = '0; lr16 = '0; w12 = '0; w20 = '0; w24 = '0; lr24 = '0;
        wait_cyc(1);
        check({tag, " bclk@1"}, 64'(b16), 64'd0);
        wait_cyc(2);
        check({tag, " bclk@2"}, 64'(b16), 64'd1);
        for (int n = 1; n <= 32 * nframes; n++) begin
            if (n == 32) begin
                wait_cyc(127);
                check({tag, " strobe@127"}, 64'(s16), 64'd0);
            end
            if (n == 33) begin
                wait_cyc(129);
                check({tag, " strobe@129"}, 64'(s16), 64'd0);
            end
            if (n == 64) begin
                wait_cyc(255);
                check({tag, " strobe24@255"}, 64'(s24), 64'd0);
            end
            wait_cyc(4 * n);
            if (n == 1)  check({tag, " bclk@4"}, 64'(b16), 64'd0);
            if (n == 32) check({tag, " strobe@128"}, 64'(s16), 64'd1);
            if (n == 64) check({tag, " strobe24@256"}, 64'(s24), 64'd1);
            w16  = {w16[30:0], d16};
            lr16 = {lr16[30:0], l16};
            w12  = {w12[30:0], d12};
            w20  = {w20[30:0], d20};
            if ((n - 1) / 64 == 1) begin
                w24  = {w24[62:0], d24};
                lr24 = {lr24[62:0], l24};
            end
            if (n == 38) in16 = 16'h1234;
            if (n == 70) in16 = 16'h5678;
            if (n % 32 == 0) begin
                f = n / 32 - 1;
                check($sformatf("%s data16 frame%0d", tag, f), 64'(w16), 64'({exp16[f], exp16[f]}));
                check($sformatf("%s lrck16 frame%0d", tag, f), 64'(lr16), 64'(32'h0001_FFFE));
                if (f == 1) begin
                    check({tag, " data12 fmt"}, 64'(w12), 64'(32'hABC0_ABC0));
                    check({tag, " data20 fmt"}, 64'(w20), 64'(32'hFEDC_FEDC));
                end
            end
            if (n == 128) begin
                check({tag, " data24 pad"}, w24, 64'h7FFF_FF00_7FFF_FF00);
                check({tag, " lrck24"}, lr24, 64'h0000_0001_FFFF_FFFE);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        total = 0;
        bad   = 0;
        exp16[0] = 16'h0000;
        exp16[1] = 16'h8001;
        exp16[2] = 16'h1234;
        exp16[3] = 16'h5678;
        in16  = 16'h8001;
        in12  = 12'hABC;
        in20  = 20'hFEDCB;
        in24  = 24'h7FFFFF;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("reset bclk",   64'(b16), 64'd0);
        check("reset lrck",   64'(l16), 64'd0);
        check("reset data",   64'(d16), 64'd0);
        check("reset strobe", 64'(s16), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frames(4, "rel");

        // Frame 4, pos 20: BCLK high, right slot, sample 0x5678 in flight.
        wait_cyc(599);
        check("pre-rst bclk", 64'(b16), 64'd1);
        check("pre-rst lrck", 64'(l16), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst bclk",   64'(b16), 64'd0);
        check("midrst lrck",   64'(l16), 64'd0);
        check("midrst data",   64'(d16), 64'd0);
        check("midrst strobe", 64'(s16), 64'd0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        run_frames(1, "rerel");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
